// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array feed controller: FSM state encoding and job latency.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } sa_state_e;

    // Cycle (counted from the start-accept cycle) in which done pulses for inner dimension k on an n x n array.
    function automatic int sa_latency(input int k, input int n);
        return (k == 0) ? 2 : k + 2 * n + 2;
    endfunction

endpackage

// File: rtl/sa_feed_ctrl_if.sv
// Handshake/bus bundle between the job requester, operand buffers, feed controller and PE array edges.
// Optional job counter port present only when SA_PERF_CNT_EN is defined.
interface sa_feed_ctrl_if #(
    parameter int N     = 4,
    parameter int WDATA = 4,
    parameter int K_MAX = 16
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);

    logic                 start;
    logic [KW-1:0]        cfg_k;
    logic                 busy;
    logic                 done;
    logic                 pe_clr_n;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [N*WDATA-1:0]   a_rd_data;
    logic [N*WDATA-1:0]   b_rd_data;
    logic [N*WDATA-1:0]   west_data;
    logic [N*WDATA-1:0]   north_data;
`ifdef SA_PERF_CNT_EN
    logic [15:0]          job_cnt;
`endif

    modport master (
`ifdef SA_PERF_CNT_EN
        input  job_cnt,
`endif
        output start, cfg_k, a_rd_data, b_rd_data,
        input  busy, done, pe_clr_n, rd_en, rd_addr, west_data, north_data
    );

    modport slave (
`ifdef SA_PERF_CNT_EN
        output job_cnt,
`endif
        input  start, cfg_k, a_rd_data, b_rd_data,
        output busy, done, pe_clr_n, rd_en, rd_addr, west_data, north_data
    );

endinterface

// File: rtl/sa_skew_lane.sv
// DEPTH-stage delay line used to skew one operand lane onto the PE array edge.
module sa_skew_lane #(
    parameter int DEPTH = 1,
    parameter int WDATA = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WDATA-1:0] d_i,
    output logic [WDATA-1:0] q_o
);

    logic [DEPTH-1:0][WDATA-1:0] sr_q;

    // NOTE: these flops feed the PE multipliers directly, so they are reset; stale values would be accumulated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) begin
                sr_q[s] <= sr_q[s-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_feed_ctrl.sv
// Job sequencer for an NxN systolic array: clear, stream k, skew operands onto west/north edges, drain, done.
// Define SA_PERF_CNT_EN to add the saturating completed-job counter (job_cnt).
module sa_feed_ctrl
    import sa_pkg::*;
#(
    parameter int N     = 4,
    parameter int WDATA = 4,
    parameter int K_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sa_feed_ctrl_if.slave bus
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);
    localparam int CW = $clog2(K_MAX + 2 * N + 3);

    sa_state_e          state_q;
    logic [KW-1:0]      keff_q;
    logic [KW-1:0]      keff_d;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               clr_n_q;
    logic               rd_en_q;
    logic               rd_vld_q;
    logic [AW-1:0]      rd_addr_q;
    logic [N*WDATA-1:0] a_in;
    logic [N*WDATA-1:0] b_in;
    logic [N*WDATA-1:0] west_w;
    logic [N*WDATA-1:0] north_w;

    assign keff_d = (bus.cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : bus.cfg_k;

    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            keff_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_n_q   <= 1'b1;
            rd_en_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld_q <= rd_en_q;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= CLEAR;
                        keff_q  <= keff_d;
                        busy_q  <= 1'b1;
                        clr_n_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_n_q <= 1'b1;
                    cnt_q   <= CW'(1);
                    if (keff_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= FEED;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                FEED: begin
                    // cnt_q holds the number of reads issued including the current one
                    if (cnt_q == CW'(keff_q)) begin
                        state_q   <= DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        cnt_q     <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                        cnt_q     <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_q == CW'(2 * N - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Zero bubbles whenever no read is returning, so PEs only ever see 0*0 outside the job.
    assign a_in = rd_vld_q ? bus.a_rd_data : '0;
    assign b_in = rd_vld_q ? bus.b_rd_data : '0;

    for (genvar g = 0; g < N; g++) begin : g_lane
        sa_skew_lane #(.DEPTH(g + 1), .WDATA(WDATA)) u_west (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (a_in[g*WDATA +: WDATA]),
            .q_o   (west_w[g*WDATA +: WDATA])
        );
        sa_skew_lane #(.DEPTH(g + 1), .WDATA(WDATA)) u_north (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (b_in[g*WDATA +: WDATA]),
            .q_o   (north_w[g*WDATA +: WDATA])
        );
    end

`ifdef SA_PERF_CNT_EN
    logic [15:0] job_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_cnt_q <= '0;
        end else if (done_q && job_cnt_q != 16'hFFFF) begin
            job_cnt_q <= job_cnt_q + 16'd1;
        end
    end

    assign bus.job_cnt = job_cnt_q;
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pe_clr_n   = clr_n_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.west_data  = west_w;
    assign bus.north_data = north_w;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Self-checking bench for sa_feed_ctrl: operand buffer model, behavioural PE array, scoreboard of reads and jobs.
module tb_sa_feed_ctrl;
    import sa_pkg::*;

    localparam int N     = 4;
    localparam int WDATA = 4;
    localparam int K_MAX = 16;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int RW    = 8;

    typedef struct packed {
        int t;
        int addr;
    } rd_exp_t;

    typedef struct packed {
        int                  t;
        logic [N*N*RW-1:0]   res;
    } job_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   jobs_done = 0;

    logic [WDATA-1:0] a_m [K_MAX][N];
    logic [WDATA-1:0] b_m [K_MAX][N];
    logic [WDATA-1:0] pa_q [N][N];
    logic [WDATA-1:0] pb_q [N][N];
    logic [RW-1:0]    acc_q [N][N];

    rd_exp_t  rd_q[$];
    job_exp_t job_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_feed_ctrl_if #(.N(N), .WDATA(WDATA), .K_MAX(K_MAX)) bus ();

    sa_feed_ctrl #(.N(N), .WDATA(WDATA), .K_MAX(K_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Operand buffers: registered read, junk on the bus when not reading.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            bus.a_rd_data[i*WDATA +: WDATA] <= bus.rd_en ? a_m[bus.rd_addr][i] : WDATA'($urandom);
            bus.b_rd_data[i*WDATA +: WDATA] <= bus.rd_en ? b_m[bus.rd_addr][i] : WDATA'($urandom);
        end
    end

    // Behavioural output-stationary PE array with 8-bit wrapping accumulators.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [WDATA-1:0] ai, bi;
                if (j == 0) ai = bus.west_data[i*WDATA +: WDATA];
                else        ai = pa_q[i][j-1];
                if (i == 0) bi = bus.north_data[j*WDATA +: WDATA];
                else        bi = pb_q[i-1][j];
                pa_q[i][j] <= ai;
                pb_q[i][j] <= bi;
                if (!rst_n || !bus.pe_clr_n) acc_q[i][j] <= '0;
                else acc_q[i][j] <= acc_q[i][j] + RW'(ai) * RW'(bi);
            end
        end
    end

    function automatic logic [N*N*RW-1:0] exp_res(input int keff);
        logic [N*N*RW-1:0] r;
        logic [RW-1:0]     s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < keff; k++) s = s + RW'(a_m[k][i]) * RW'(b_m[k][j]);
                r[(i*N+j)*RW +: RW] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [N*N*RW-1:0] pack_acc();
        logic [N*N*RW-1:0] r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[(i*N+j)*RW +: RW] = acc_q[i][j];
        return r;
    endfunction

    // Scoreboard consumer: every read and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.rd_en === 1'b1) begin
                rd_exp_t e;
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", bus.rd_en, 1'b0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_cycle", cyc, e.t);
                    check("rd_addr", bus.rd_addr, e.addr);
                end
            end
            if (bus.done === 1'b1) begin
                job_exp_t e;
                if (job_q.size() == 0) begin
                    check("done_unexpected", bus.done, 1'b0);
                end else begin
                    e = job_q.pop_front();
                    check("done_cycle", cyc, e.t);
                    check("results", pack_acc(), e.res);
                    check("busy_at_done", bus.busy, 1'b1);
                    jobs_done++;
                end
            end
        end
    end

    task automatic fill_random();
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                a_m[k][i] = WDATA'($urandom);
                b_m[k][i] = WDATA'($urandom);
            end
    endtask

    // Called at a negedge; drives start for one cycle and queues the expected reads and result.
    task automatic launch(input int kcfg, output int t0);
        int keff;
        keff = (kcfg > K_MAX) ? K_MAX : kcfg;
        bus.cfg_k = KW'(kcfg);
        bus.start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < keff; k++) rd_q.push_back('{t: t0 + 2 + k, addr: k});
        job_q.push_back('{t: t0 + sa_latency(keff, N), res: exp_res(keff)});
        @(negedge clk);
        bus.start = 1'b0;
        check("clr_low", bus.pe_clr_n, 1'b0);
        check("busy_rise", bus.busy, 1'b1);
    endtask

    task automatic run_to_done(input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) check({tag, "_timeout"}, bus.done, 1'b1);
        @(negedge clk);
        check({tag, "_busy_fall"}, bus.busy, 1'b0);
        check({tag, "_drained"}, rd_q.size() + job_q.size(), 0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int t0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.cfg_k = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_clr_n", bus.pe_clr_n, 1'b1);
        check("rst_rd_en", bus.rd_en, 1'b0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_west", bus.west_data, 0);
        check("rst_north", bus.north_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity A times B = 1..16 row-major (16 wraps to 0 in a 4-bit operand).
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                a_m[k][i] = (k == i) ? WDATA'(1) : WDATA'(0);
                b_m[k][i] = WDATA'(k * N + i + 1);
            end
        launch(4, t0);
        run_to_done("t1");
        check("t1_pe12", acc_q[1][2], 8'd7);
        check("t1_west_idle", bus.west_data, 0);
        check("t1_north_idle", bus.north_data, 0);

        // All operands 15: 4*225 = 900 wraps to 132.
        for (int k = 0; k < K_MAX; k++)
            for (int i = 0; i < N; i++) begin
                a_m[k][i] = 4'hF;
                b_m[k][i] = 4'hF;
            end
        launch(4, t0);
        run_to_done("t2");
        check("t2_pe00", acc_q[0][0], 8'd132);
        check("t2_pe33", acc_q[3][3], 8'd132);

        // Empty job: clear then done two cycles after start.
        launch(0, t0);
        run_to_done("t3");
        check("t3_pe33", acc_q[3][3], 8'd0);

        // Saturated inner dimension with ignored start pulses mid-job and in the done cycle.
        fill_random();
        launch(20, t0);
        wait_until(t0 + 5);
        bus.cfg_k = KW'(3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_busy_mid", bus.busy, 1'b1);
        wait_until(t0 + 26);
        check("t4_done_26", bus.done, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_busy_after", bus.busy, 1'b0);
        repeat (12) @(negedge clk);
        check("t4_drained", rd_q.size() + job_q.size(), 0);

        // Back-to-back: second start in the first IDLE cycle.
        fill_random();
        launch(4, t0);
        run_to_done("t5a");
        fill_random();
        launch(3, t0);
        run_to_done("t5b");

        // Reset in the middle of FEED.
        fill_random();
        launch(8, t0);
        wait_until(t0 + 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_rd_en", bus.rd_en, 1'b0);
        check("t6_west", bus.west_data, 0);
        check("t6_north", bus.north_data, 0);
        rd_q.delete();
        job_q.delete();
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_done", bus.done, 1'b0);
`ifdef SA_PERF_CNT_EN
        check("t6_job_cnt", bus.job_cnt, jobs_done);
`endif

        // Recovery job after reset.
        fill_random();
        launch(2, t0);
        run_to_done("t7");
`ifdef SA_PERF_CNT_EN
        check("job_cnt_final", bus.job_cnt, jobs_done);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
